// File: rtl/mux_pkg.sv
// Shared definitions for the datapath steering blocks: default data width,
// lane count, sel encodings and the sel-to-lane decode.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int NUM_LANES     = 4;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    // One-hot lane select from the 2-bit destination code.
    function automatic logic [NUM_LANES-1:0] sel_decode(input logic [1:0] sel);
        // NOTE: default assignment first so every path of the case assigns the result (no latch).
        sel_decode = '0;
        unique case (sel)
            SEL_A: sel_decode[0] = 1'b1;
            SEL_B: sel_decode[1] = 1'b1;
            SEL_C: sel_decode[2] = 1'b1;
            SEL_D: sel_decode[3] = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/demux_1to4_if.sv
// Bus bundle for the 1-to-4 demultiplexer: the tagged input stream plus the
// four output lanes with their valid/ready pairs and the status outputs.
interface demux_1to4_if #(
    parameter int WIDTH = mux_pkg::DEFAULT_WIDTH
);

    logic [WIDTH-1:0] data_in;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic             A_valid;
    logic             B_valid;
    logic             C_valid;
    logic             D_valid;
    logic             A_ready;
    logic             B_ready;
    logic             C_ready;
    logic             D_ready;

    logic [3:0]       lane_full;
    logic [7:0]       accept_cnt;

    // Producer/consumer side: drives the input word and the lane readies.
    modport master (
        output data_in, sel, in_valid,
        output A_ready, B_ready, C_ready, D_ready,
        input  in_ready,
        input  A, B, C, D,
        input  A_valid, B_valid, C_valid, D_valid,
        input  lane_full, accept_cnt
    );

    // Demultiplexer side.
    modport slave (
        input  data_in, sel, in_valid,
        input  A_ready, B_ready, C_ready, D_ready,
        output in_ready,
        output A, B, C, D,
        output A_valid, B_valid, C_valid, D_valid,
        output lane_full, accept_cnt
    );

endinterface

// File: rtl/demux_lane.sv
// Single-entry output lane: holds one word with a valid/ready handshake.
// A write replaces the word and keeps valid set, so a lane that is drained
// and refilled in the same cycle sustains one word per cycle.
module demux_lane #(
    parameter int WIDTH = mux_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             open
);

    // The lane can take a word when it is empty or its word leaves this cycle.
    assign open = !valid || ready;

    // Lane register: write has priority over drain; stall holds data and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset too, because its value is visible on the lane outputs.
            data  <= '0;
            valid <= 1'b0;
        end else if (wr_en) begin
            // NOTE: non-blocking assignments for all clocked state so every register sees pre-edge values.
            data  <= wr_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer. Each input word is steered by sel into one
// of four single-entry lanes; a stalled lane only refuses words aimed at it.
module demux_1to4 #(
    parameter int WIDTH = mux_pkg::DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    demux_1to4_if.slave  bus
);

    import mux_pkg::*;

    logic [NUM_LANES-1:0] lane_ready;
    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] lane_open;
    logic [NUM_LANES-1:0] wr_en;
    logic [WIDTH-1:0]     lane_data [NUM_LANES];
    logic                 accept;
    logic [7:0]           accept_cnt;

    assign lane_ready = {bus.D_ready, bus.C_ready, bus.B_ready, bus.A_ready};

    // Only the addressed lane decides whether the input word is taken.
    assign bus.in_ready = lane_open[bus.sel];
    assign accept       = bus.in_valid && bus.in_ready;
    assign wr_en        = accept ? sel_decode(bus.sel) : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[i]),
            .wr_data (bus.data_in),
            .ready   (lane_ready[i]),
            .data    (lane_data[i]),
            .valid   (lane_valid[i]),
            .open    (lane_open[i])
        );
    end

    // Accepted-word counter, wraps modulo 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_cnt <= 8'd0;
        end else if (accept) begin
            accept_cnt <= accept_cnt + 8'd1;
        end
    end

    assign bus.A          = lane_data[SEL_A];
    assign bus.B          = lane_data[SEL_B];
    assign bus.C          = lane_data[SEL_C];
    assign bus.D          = lane_data[SEL_D];
    assign bus.A_valid    = lane_valid[SEL_A];
    assign bus.B_valid    = lane_valid[SEL_B];
    assign bus.C_valid    = lane_valid[SEL_C];
    assign bus.D_valid    = lane_valid[SEL_D];
    assign bus.lane_full  = lane_valid;
    assign bus.accept_cnt = accept_cnt;

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: the stimulus side keeps a per-lane queue
// of words that should be in flight, and a separate monitor pops and compares
// each word as the lane hands it to its consumer.
module tb_demux_1to4;

    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux_1to4_if #(.WIDTH(8)) bus ();

    demux_1to4 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [NUM_LANES][$];
    int         resident [NUM_LANES];
    int         deliv [NUM_LANES];
    logic [7:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic get_valid(input int l);
        case (l)
            0:       return bus.A_valid;
            1:       return bus.B_valid;
            2:       return bus.C_valid;
            default: return bus.D_valid;
        endcase
    endfunction

    function automatic logic [7:0] get_data(input int l);
        case (l)
            0:       return bus.A;
            1:       return bus.B;
            2:       return bus.C;
            default: return bus.D;
        endcase
    endfunction

    function automatic logic get_ready(input int l);
        case (l)
            0:       return bus.A_ready;
            1:       return bus.B_ready;
            2:       return bus.C_ready;
            default: return bus.D_ready;
        endcase
    endfunction

    task automatic set_ready(input logic [3:0] r);
        bus.A_ready = r[0];
        bus.B_ready = r[1];
        bus.C_ready = r[2];
        bus.D_ready = r[3];
    endtask

    task automatic clear_model();
        for (int l = 0; l < NUM_LANES; l++) begin
            exp_q[l].delete();
            resident[l] = 0;
        end
        exp_cnt = 8'd0;
    endtask

    // One cycle of stimulus. Inputs change just after the rising edge; at the
    // falling edge the expected in_ready/accept_cnt are checked and an accepted
    // word is queued for its lane.
    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, output logic acc);
        logic exp_rdy;
        bus.in_valid = v;
        bus.sel      = s;
        bus.data_in  = d;
        @(negedge clk);
        for (int l = 0; l < NUM_LANES; l++) resident[l] = exp_q[l].size();
        exp_rdy = (exp_q[s].size() == 0) || get_ready(int'(s));
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("accept_cnt", 32'(bus.accept_cnt), 32'(exp_cnt));
        acc = v && exp_rdy;
        if (acc) begin
            exp_q[s].push_back(d);
            exp_cnt = exp_cnt + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom), 8'($urandom), acc);
    endtask

    // Monitor: lane valid must match whether a word is resident; the resident
    // word must be the oldest queued one, and it leaves when ready is high.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                check($sformatf("lane%0d_valid", l), 32'(get_valid(l)), 32'(resident[l] != 0));
                if (get_valid(l) && exp_q[l].size() != 0) begin
                    check($sformatf("lane%0d_data", l), 32'(get_data(l)), 32'(exp_q[l][0]));
                    if (get_ready(l)) begin
                        void'(exp_q[l].pop_front());
                        deliv[l]++;
                    end
                end
            end
            check("lane_full", 32'(bus.lane_full),
                  32'({bus.D_valid, bus.C_valid, bus.B_valid, bus.A_valid}));
        end
    end

    initial begin
        logic       acc;
        logic       held;
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
        logic [7:0] cnt_start;
        int         deliv_start;

        for (int l = 0; l < NUM_LANES; l++) deliv[l] = 0;
        clear_model();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.sel      = SEL_A;
        bus.data_in  = 8'h00;
        set_ready(4'b1111);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_cnt", 32'(bus.accept_cnt), 32'd0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: asynchronous reset mid-cycle while lane B holds a word.
        set_ready(4'b1101);
        drive(1'b1, SEL_B, 8'h3C, acc);
        drive(1'b0, SEL_B, 8'h00, acc);
        check("pre_reset_B_valid", 32'(bus.B_valid), 32'd1);
        check("pre_reset_in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_B_valid", 32'(bus.B_valid), 32'd0);
        check("async_B", 32'(bus.B), 32'd0);
        check("async_cnt", 32'(bus.accept_cnt), 32'd0);
        check("async_in_ready", 32'(bus.in_ready), 32'd1);
        clear_model();
        set_ready(4'b1111);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 5: 256 accepted words wrap the counter, then 10 idle cycles.
        cnt_start = exp_cnt;
        for (int i = 0; i < 256; i++) drive(1'b1, 2'($urandom), 8'($urandom), acc);
        idle(10);
        check("wrap_cnt", 32'(bus.accept_cnt), 32'(cnt_start));

        // Test 2: one word per lane on back-to-back cycles.
        deliv_start = deliv[0] + deliv[1] + deliv[2] + deliv[3];
        drive(1'b1, SEL_A, 8'h01, acc);
        drive(1'b1, SEL_B, 8'h02, acc);
        drive(1'b1, SEL_C, 8'h03, acc);
        drive(1'b1, SEL_D, 8'h04, acc);
        idle(2);
        check("route_cnt", 32'(bus.accept_cnt), 32'd4);
        check("route_deliv", 32'(deliv[0] + deliv[1] + deliv[2] + deliv[3] - deliv_start), 32'd4);

        // Tests 3 and 4: lane C stalls; lane D is still reachable.
        set_ready(4'b1011);
        drive(1'b1, SEL_C, 8'hAA, acc);
        drive(1'b1, SEL_D, 8'h55, acc);
        check("nonblock_accept", 32'(acc), 32'd1);
        drive(1'b1, SEL_C, 8'hBB, acc);
        drive(1'b1, SEL_C, 8'hBB, acc);
        check("stall_C", 32'(bus.C), 32'hAA);
        check("stall_refused", 32'(acc), 32'd0);
        set_ready(4'b1111);
        drive(1'b1, SEL_C, 8'hBB, acc);
        check("stall_release_accept", 32'(acc), 32'd1);
        check("C_after_release", 32'(bus.C), 32'hBB);
        check("C_valid_after_release", 32'(bus.C_valid), 32'd1);
        idle(2);

        // Test 6: 20 back-to-back words into lane A.
        deliv_start = deliv[0];
        for (int i = 0; i < 20; i++) drive(1'b1, SEL_A, 8'(i), acc);
        idle(2);
        check("stream_deliv", 32'(deliv[0] - deliv_start), 32'd20);

        // Randomised traffic with random consumer back-pressure.
        held = 1'b0;
        v    = 1'b0;
        s    = SEL_A;
        d    = 8'h00;
        for (int i = 0; i < 400; i++) begin
            set_ready(4'($urandom));
            if (!held) begin
                v = ($urandom_range(0, 3) != 0);
                s = 2'($urandom);
                d = 8'($urandom);
            end
            drive(v, s, d, acc);
            held = v && !acc;
        end

        // Drain everything and confirm nothing is left in flight.
        set_ready(4'b1111);
        idle(4);
        for (int l = 0; l < NUM_LANES; l++)
            check($sformatf("drain_lane%0d", l), 32'(exp_q[l].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
